// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
    MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if;

  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);

endinterface

// File: rtl/multicycle_ctrl_opclass_dec.sv
// Combinational opcode/funct3 classifier: picks the state that follows DECODE
// and qualifies branch conditions.
module ctrl_opclass_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output state_t     next_class,
  output logic       illegal,
  output logic       is_store,
  output logic       br_valid,
  output logic       br_ne
);

  always_comb begin
    next_class = TRAP;
    illegal    = 1'b1;
    case (opcode)
      OP_R:               begin next_class = EXEC_R;   illegal = 1'b0; end
      OP_IMM:             begin next_class = EXEC_I;   illegal = 1'b0; end
      OP_LOAD, OP_STORE:  begin next_class = MEM_ADDR; illegal = 1'b0; end
      OP_BRANCH:          begin next_class = BRANCH;   illegal = 1'b0; end
      OP_JAL:             begin next_class = JAL;      illegal = 1'b0; end
      default: ;
    endcase
  end

  assign is_store = (opcode == OP_STORE);
  assign br_valid = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  assign br_ne    = (funct3 == F3_BNE);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH..WRITEBACK over a shared memory port,
// with bus timeout, illegal-instruction trap and retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             mem_req, mem_we, mem_addr_sel;

  state_t next_class;
  logic   illegal, is_store, br_valid, br_ne;

  // funct7_5 only steers SUB/SRA inside the ALU decoder; sequencing ignores it.
  logic unused_ok;
  assign unused_ok = funct7_5;

  ctrl_opclass_dec u_dec (
    .opcode     (opcode),
    .funct3     (funct3),
    .next_class (next_class),
    .illegal    (illegal),
    .is_store   (is_store),
    .br_valid   (br_valid),
    .br_ne      (br_ne)
  );

  assign mem.mem_req      = mem_req;
  assign mem.mem_we       = mem_we;
  assign mem.mem_addr_sel = mem_addr_sel;

  // Completion in the last allowed cycle beats the timeout.
  assign tmo_hit = mem_req && !mem.mem_ready && (tmo_cnt == TMO_LAST);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    case (state)
      FETCH: if (run) begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE:   alu_src_b = SRCB_IMM;
      EXEC_R:   begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
      EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALU_FUNCT; end
      MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      MEM_RD:   begin mem_req = 1'b1; mem_addr_sel = 1'b1; end
      MEM_WR:   begin mem_req = 1'b1; mem_addr_sel = 1'b1; mem_we = 1'b1; end
      WB_ALU:   reg_write = 1'b1;
      WB_MEM:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = br_valid && (alu_zero ^ br_ne);
      end
      JAL:      begin pc_write = 1'b1; pc_src = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      tmo_cnt    <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= TRAP_NONE;
    end else begin
      tmo_cnt <= (mem_req && !mem.mem_ready) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) begin
        state      <= TRAP;
        trap       <= 1'b1;
        trap_cause <= TRAP_TIMEOUT;
      end else begin
        case (state)
          FETCH:    if (run && mem.mem_ready) state <= DECODE;
          DECODE: begin
            state <= next_class;
            if (illegal) begin
              trap       <= 1'b1;
              trap_cause <= TRAP_ILLEGAL;
            end
          end
          EXEC_R, EXEC_I: state <= WB_ALU;
          MEM_ADDR: state <= is_store ? MEM_WR : MEM_RD;
          MEM_RD:   if (mem.mem_ready) state <= WB_MEM;
          MEM_WR: if (mem.mem_ready) begin
            state   <= FETCH;
            instret <= instret + CNT_W'(1);
          end
          WB_ALU, WB_MEM, JAL: begin
            state   <= FETCH;
            instret <= instret + CNT_W'(1);
          end
          BRANCH: begin
            if (br_valid) begin
              state   <= FETCH;
              instret <= instret + CNT_W'(1);
            end else begin
              state      <= TRAP;
              trap       <= 1'b1;
              trap_cause <= TRAP_ILLEGAL;
            end
          end
          TRAP: ;
          default: begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= TRAP_ILLEGAL;
          end
        endcase
      end
    end
  end

endmodule
